// File: rtl/vga_port_arbiter_if.sv
// ============================================================================
// vga_port_arbiter_if : requester-side and VGA-side bus of the plot port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface vga_port_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   rel;
  logic [NUM_REQ-1:0]   plot_en;
  logic [9*NUM_REQ-1:0] x_in;
  logic [8*NUM_REQ-1:0] y_in;
  logic [3*NUM_REQ-1:0] color_in;
  logic [NUM_REQ-1:0]   grant;
  logic                 vga_plot;
  logic [8:0]           vga_x;
  logic [7:0]           vga_y;
  logic [2:0]           vga_color;
  logic                 busy;
  logic                 timeout;

  modport master (
    output req, rel, plot_en, x_in, y_in, color_in,
    input  grant, vga_plot, vga_x, vga_y, vga_color, busy, timeout
  );

  modport slave (
    input  req, rel, plot_en, x_in, y_in, color_in,
    output grant, vga_plot, vga_x, vga_y, vga_color, busy, timeout
  );
endinterface

`default_nettype wire

// File: rtl/vga_port_arbiter.sv
// ============================================================================
// vga_port_arbiter : round-robin burst arbiter for the shared VGA plot port
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_port_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 76800,
  parameter int CNT_W     = 17
) (
  input  logic               clock_i,
  input  logic               reset_i,
  vga_port_arbiter_if.slave  port_io
);

  localparam int               IDX_W      = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_GAP     = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               vga_plot_q, vga_plot_d;
  logic [8:0]         vga_x_q, vga_x_d;
  logic [7:0]         vga_y_q, vga_y_d;
  logic [2:0]         vga_color_q, vga_color_d;
  logic               timeout_q, timeout_d;

  logic [8:0]         w_x     [NUM_REQ];
  logic [7:0]         w_y     [NUM_REQ];
  logic [2:0]         w_color [NUM_REQ];
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  int                 w_idx;
  logic               w_rel;
  logic               w_wdog;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_x[i]     = port_io.x_in[9*i +: 9];
    assign w_y[i]     = port_io.y_in[8*i +: 8];
    assign w_color[i] = port_io.color_in[3*i +: 3];
  end

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!w_found && port_io.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(w_idx);
      end
    end
  end

  assign w_rel  = port_io.rel[owner_q];
  assign w_wdog = (burst_cnt_q == BURST_LAST);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    vga_plot_d  = 1'b0;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          grant_d     = NUM_REQ'(1) << w_win;
          owner_d     = w_win;
          rr_ptr_d    = (w_win == IDX_LAST) ? '0 : w_win + 1'b1;
          burst_cnt_d = '0;
          state_d     = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        vga_plot_d  = port_io.plot_en[owner_q];
        if (port_io.plot_en[owner_q]) begin
          vga_x_d     = w_x[owner_q];
          vga_y_d     = w_y[owner_q];
          vga_color_d = w_color[owner_q];
        end
        burst_cnt_d = burst_cnt_q + 1'b1;
        // The exit-cycle pixel above is still written; a release wins over the watchdog.
        if (w_rel || !port_io.req[owner_q] || w_wdog) begin
          grant_d   = '0;
          state_d   = ST_GAP;
          timeout_d = w_wdog && !w_rel;
        end
      end
      ST_GAP: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      vga_plot_q  <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      vga_plot_q  <= vga_plot_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      timeout_q   <= timeout_d;
    end
  end

  assign port_io.grant     = grant_q;
  assign port_io.vga_plot  = vga_plot_q;
  assign port_io.vga_x     = vga_x_q;
  assign port_io.vga_y     = vga_y_q;
  assign port_io.vga_color = vga_color_q;
  assign port_io.busy      = (state_q != ST_IDLE);
  assign port_io.timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_port_arbiter.sv
// ============================================================================
// tb_vga_port_arbiter : directed self-checking bench for vga_port_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_port_arbiter;

  localparam int NUM_REQ = 3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  vga_port_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  vga_port_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (8),
    .CNT_W     (4)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .port_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int c);
    bus.x_in[9*i +: 9]     = 9'(x);
    bus.y_in[8*i +: 8]     = 8'(y);
    bus.color_in[3*i +: 3] = 3'(c);
  endtask

  initial begin
    logic [2:0] exp_g [4];
    exp_g = '{3'b010, 3'b100, 3'b001, 3'b010};
    n_cmp = 0;
    n_bad = 0;
    rst          = 1'b1;
    bus.req      = '0;
    bus.rel      = '0;
    bus.plot_en  = '0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    bus.color_in = '0;

    // Reset state
    tick();
    tick();
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_plot", 32'(bus.vga_plot), 32'd0);
    check("rst_x", 32'(bus.vga_x), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);

    // Single requester grant and pixel latency
    rst     = 1'b0;
    bus.req = 3'b001;
    tick();
    check("t1_grant", 32'(bus.grant), 32'b001);
    check("t1_busy", 32'(bus.busy), 32'd1);
    bus.plot_en = 3'b001;
    set_pix(0, 5, 7, 3);
    tick();
    check("t1_plot", 32'(bus.vga_plot), 32'd1);
    check("t1_x", 32'(bus.vga_x), 32'd5);
    check("t1_y", 32'(bus.vga_y), 32'd7);
    check("t1_c", 32'(bus.vga_color), 32'd3);
    bus.plot_en = 3'b000;
    tick();
    check("hold_plot", 32'(bus.vga_plot), 32'd0);
    check("hold_x", 32'(bus.vga_x), 32'd5);

    // Non-owner plot_en ignored
    bus.plot_en = 3'b011;
    set_pix(0, 6, 8, 2);
    set_pix(1, 100, 50, 5);
    tick();
    check("t3_x_owner", 32'(bus.vga_x), 32'd6);
    check("t3_plot", 32'(bus.vga_plot), 32'd1);
    bus.plot_en = 3'b010;
    tick();
    check("t3_plot_nonowner", 32'(bus.vga_plot), 32'd0);
    check("t3_x_hold", 32'(bus.vga_x), 32'd6);

    // Release with same-cycle pixel at the screen corner
    bus.rel     = 3'b001;
    bus.plot_en = 3'b001;
    set_pix(0, 319, 239, 7);
    tick();
    check("t5_plot", 32'(bus.vga_plot), 32'd1);
    check("t5_x", 32'(bus.vga_x), 32'd319);
    check("t5_y", 32'(bus.vga_y), 32'd239);
    check("t5_c", 32'(bus.vga_color), 32'd7);
    check("t5_grant_gap", 32'(bus.grant), 32'd0);
    check("t5_busy_gap", 32'(bus.busy), 32'd1);
    check("t5_timeout", 32'(bus.timeout), 32'd0);
    bus.rel     = '0;
    bus.plot_en = '0;
    bus.req     = '0;
    tick();
    check("t5_busy_idle", 32'(bus.busy), 32'd0);
    check("t5_plot_idle", 32'(bus.vga_plot), 32'd0);

    // Round-robin rotation, rr_ptr is now 1
    bus.req = 3'b111;
    tick();
    for (int n = 0; n < 4; n++) begin
      check($sformatf("rr_grant%0d", n), 32'(bus.grant), 32'(exp_g[n]));
      if (n == 3) break;
      tick();
      tick();
      tick();
      check($sformatf("rr_hold%0d", n), 32'(bus.grant), 32'(exp_g[n]));
      bus.rel = exp_g[n];
      tick();
      bus.rel = '0;
      check($sformatf("rr_gap%0d", n), 32'(bus.grant), 32'd0);
      tick();
      check($sformatf("rr_idle%0d", n), 32'(bus.grant), 32'd0);
      tick();
    end

    // Watchdog: owner 1 never releases, 8 granted cycles
    for (int n = 0; n < 7; n++) tick();
    check("wd_grant_7", 32'(bus.grant), 32'b010);
    check("wd_timeout_7", 32'(bus.timeout), 32'd0);
    tick();
    check("wd_grant_drop", 32'(bus.grant), 32'd0);
    check("wd_timeout", 32'(bus.timeout), 32'd1);
    tick();
    check("wd_timeout_pulse", 32'(bus.timeout), 32'd0);
    tick();
    check("wd_next", 32'(bus.grant), 32'b100);

    // Mid-burst reset with an in-flight pixel
    bus.plot_en = 3'b100;
    set_pix(2, 50, 60, 4);
    rst = 1'b1;
    tick();
    check("t6_grant", 32'(bus.grant), 32'd0);
    check("t6_plot", 32'(bus.vga_plot), 32'd0);
    check("t6_x", 32'(bus.vga_x), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);
    rst         = 1'b0;
    bus.plot_en = '0;
    tick();
    check("t6_rr_first", 32'(bus.grant), 32'b001);

    // Owner dropping req ends the burst without timeout
    bus.req = 3'b000;
    tick();
    check("drop_grant", 32'(bus.grant), 32'd0);
    check("drop_timeout", 32'(bus.timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
